// File: rtl/vm_core_p.sv
`timescale 1ns/1ps
// vm_core_p: multi-cycle hex-display VM core (PC, regfile, ALU, control FSM) with a req/ack memory port.
// Define VM_CORE_BREAKPOINT_EN to add the free-run PC breakpoint (bp_en / bp_addr / bp_hit).
module vm_core_p #(
   parameter int DW = 32,
   parameter int AW = 8,
   parameter int RW = 4
) (
   input  logic          clk,
   input  logic          rst,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_rdata,
   input  logic          go,
   input  logic          run_mode,
   input  logic [7:0]    sw_in,
   input  logic [RW-1:0] dbg_sel,
   output logic [DW-1:0] dbg_data,
   output logic [AW-1:0] pc,
   output logic [2:0]    state,
   output logic [1:0]    flags,
   output logic          halted
`ifdef VM_CORE_BREAKPOINT_EN
   ,
   input  logic          bp_en,
   input  logic [AW-1:0] bp_addr,
   output logic          bp_hit
`endif
);
   localparam int NREG = 2 ** RW;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
      S_MEM  = 3'd4, S_WB    = 3'd5, S_HALT   = 3'd6
   } state_e;

   typedef enum logic [3:0] {
      OP_NOP = 4'd0, OP_LDI = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3, OP_LD  = 4'd4,
      OP_ST  = 4'd5, OP_JMP = 4'd6, OP_JZ  = 4'd7, OP_IN  = 4'd8, OP_HLT = 4'd9
   } op_e;

   typedef struct packed {
      logic [7:0]    imm;
      logic [RW-1:0] rs;
      logic [RW-1:0] rd;
      logic [3:0]    op;
   } instr_t;

   state_e        state_q, state_d;
   instr_t        instr_q, instr_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [DW-1:0] alu_q, alu_d;
   logic          carry_q, carry_d;
   logic          flag_c_q, flag_c_d, flag_z_q, flag_z_d;
   logic [DW-1:0] regs_q [NREG];
   logic [DW-1:0] regs_d [NREG];
   logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          halted_q, halted_d;
   logic          go_prev_q;
   logic          go_rise, start_fetch, bp_stop;
   logic [DW-1:0] rd_val, rs_val, imm_dw;
   logic [AW-1:0] imm_aw;

   assign go_rise = go & ~go_prev_q;
   assign rd_val  = regs_q[instr_q.rd];
   assign rs_val  = regs_q[instr_q.rs];
   assign imm_dw  = DW'(instr_q.imm);
   assign imm_aw  = imm_dw[AW-1:0];

`ifdef VM_CORE_BREAKPOINT_EN
   logic bp_hit_q, bp_hit_d;
   assign bp_hit = bp_hit_q;
   // The go edge that resumes from a breakpoint must not trip the same breakpoint again.
   assign bp_stop = run_mode && bp_en && (pc_q == bp_addr) && !(state_q == S_IDLE && bp_hit_q);
`else
   assign bp_stop = 1'b0;
`endif

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign dbg_data  = regs_q[dbg_sel];
   assign pc        = pc_q;
   assign state     = state_q;
   assign flags     = {flag_c_q, flag_z_q};
   assign halted    = halted_q;

   always_comb begin
      // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
      state_d     = state_q;
      instr_d     = instr_q;
      pc_d        = pc_q;
      alu_d       = alu_q;
      carry_d     = carry_q;
      flag_c_d    = flag_c_q;
      flag_z_d    = flag_z_q;
      regs_d      = regs_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      halted_d    = halted_q;
      start_fetch = 1'b0;
`ifdef VM_CORE_BREAKPOINT_EN
      bp_hit_d    = bp_hit_q;
`endif
      case (state_q)
         S_IDLE: if (go_rise) start_fetch = 1'b1;
         S_FETCH: if (mem_ack) begin
            instr_d   = instr_t'({mem_rdata[31:24], mem_rdata[16 +: RW], mem_rdata[8 +: RW], mem_rdata[3:0]});
            mem_req_d = 1'b0;
            state_d   = S_DECODE;
         end
         S_DECODE: begin
            pc_d = pc_q + AW'(1);
            if (instr_q.op == OP_HLT) begin
               state_d  = S_HALT;
               halted_d = 1'b1;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_WB;
            case (instr_q.op)
               OP_LDI: alu_d = imm_dw;
               OP_ADD: {carry_d, alu_d} = {1'b0, rd_val} + {1'b0, rs_val};
               OP_SUB: begin
                  alu_d   = rd_val - rs_val;
                  carry_d = (rd_val < rs_val);
               end
               OP_IN:  alu_d = DW'(sw_in);
               OP_JMP: pc_d = imm_aw;
               OP_JZ:  if (flag_z_q) pc_d = imm_aw;
               OP_LD, OP_ST: begin
                  state_d    = S_MEM;
                  mem_req_d  = 1'b1;
                  mem_we_d   = (instr_q.op == OP_ST);
                  mem_addr_d = rs_val[AW-1:0];
                  if (instr_q.op == OP_ST) mem_wdata_d = rd_val;
               end
               default: ;
            endcase
         end
         S_MEM: if (mem_ack) begin
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            if (instr_q.op == OP_LD) alu_d = mem_rdata;
            state_d = S_WB;
         end
         S_WB: begin
            case (instr_q.op)
               OP_LDI, OP_ADD, OP_SUB, OP_LD, OP_IN: begin
                  regs_d[instr_q.rd] = alu_q;
                  flag_z_d           = (alu_q == '0);
                  if (instr_q.op == OP_ADD || instr_q.op == OP_SUB) flag_c_d = carry_q;
               end
               default: ;
            endcase
            if (run_mode) start_fetch = 1'b1;
            else          state_d     = S_IDLE;
         end
         S_HALT: ;
         default: state_d = S_IDLE;
      endcase
      // Both routes into FETCH (go edge, free-run continuation) share the breakpoint check.
      if (start_fetch) begin
         if (bp_stop) begin
            state_d = S_IDLE;
`ifdef VM_CORE_BREAKPOINT_EN
            bp_hit_d = 1'b1;
`endif
         end else begin
            state_d    = S_FETCH;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = pc_q;
`ifdef VM_CORE_BREAKPOINT_EN
            bp_hit_d   = 1'b0;
`endif
         end
      end
   end

   // NOTE: the register file sits in resettable flops because a cleared regfile is visible on dbg_data right after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         instr_q     <= '0;
         pc_q        <= '0;
         alu_q       <= '0;
         carry_q     <= 1'b0;
         flag_c_q    <= 1'b0;
         flag_z_q    <= 1'b0;
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         halted_q    <= 1'b0;
         go_prev_q   <= 1'b0;
`ifdef VM_CORE_BREAKPOINT_EN
         bp_hit_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         instr_q     <= instr_d;
         pc_q        <= pc_d;
         alu_q       <= alu_d;
         carry_q     <= carry_d;
         flag_c_q    <= flag_c_d;
         flag_z_q    <= flag_z_d;
         regs_q      <= regs_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         halted_q    <= halted_d;
         go_prev_q   <= go;
`ifdef VM_CORE_BREAKPOINT_EN
         bp_hit_q    <= bp_hit_d;
`endif
      end
   end

endmodule

// File: doc/vm_core_p.md
Name: vm_core_p

Overview:
- Parametrised multi-cycle core for the hex-display VM; successor to the fixed 8-bit-address, 16-register top level.
- Integrates PC, register file, ALU and a control FSM into a single block.
- External memory is accessed over a req/ack handshake, so wait-state memories are supported.
- Supports single-step and free-run modes.
- Exposes a debug read port that feeds the seven-segment display mux.

Parameters:
DW, 32, data/register width; must be >= 32 because instructions are 32 bits
AW, 8, memory address and PC width
RW, 4, register-address width; NREG = 2**RW

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
mem_req  out  1  memory request, held until acknowledged
mem_we  out  1  1 = write, 0 = read; valid while mem_req
mem_addr  out  AW  memory address
mem_wdata  out  DW  write data
mem_ack  in  1  transfer complete this cycle (ignored while mem_req=0)
mem_rdata  in  DW  read data, valid when mem_ack=1
go  in  1  start/step button, level; rising edge is detected internally
run_mode  in  1  1 = free-run, 0 = single-step
sw_in  in  8  switch value read by the IN instruction
dbg_sel  in  RW  register selected for the debug port
dbg_data  out  DW  combinational read of regfile[dbg_sel]
pc  out  AW  current PC
state  out  3  FSM state code
flags  out  2  {C, Z}
halted  out  1  core is in HALT

Behaviour:
- Instruction word: [3:0] opcode, [11:8] rd, [19:16] rs, [31:24] imm8.
  - Register fields use the low RW bits of each nibble.
  - imm8 is zero-extended to DW, or truncated/zero-extended to AW where it is used as an address.
- Opcodes:
  - 0 NOP
  - 1 LDI: rd = imm
  - 2 ADD: rd = rd + rs
  - 3 SUB: rd = rd - rs
  - 4 LD: rd = mem[rs[AW-1:0]]
  - 5 ST: mem[rs[AW-1:0]] = rd
  - 6 JMP: pc = imm
  - 7 JZ: pc = imm if Z = 1
  - 8 IN: rd = sw_in, zero-extended
  - 9 HLT
  - 10-15: execute as NOP
- Flags:
  - Z updated by LDI, ADD, SUB, LD and IN; Z = 1 when the written result == 0.
  - C updated by ADD (carry out of bit DW-1) and SUB (borrow: 1 when rd < rs unsigned).
  - All other opcodes leave the flags unchanged.
- Arithmetic is modulo 2**DW. PC increments modulo 2**AW, so 2**AW-1 wraps to 0.
- FSM codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
  - IDLE -> FETCH on a go rising edge.
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On ack, latch the instruction and go to DECODE.
  - DECODE: pc <= pc+1. HLT goes to HALT; all other opcodes go to EXEC.
  - EXEC: ALU result is registered and the jump target is applied. LD/ST go to MEM; all others go to WB.
  - MEM: mem_req=1. ST drives mem_we=1 and mem_wdata=rd. Leave on ack.
  - WB: regfile write and flag update happen here. Next state is FETCH if run_mode=1, otherwise IDLE.
  - HALT: absorbing; only reset leaves it. halted=1.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are stable from request until the cycle ack is sampled.
  - Zero-wait operation is allowed: ack in the first req cycle completes the transfer at that edge.
  - mem_req drops in the cycle after ack. At most one outstanding transfer.
- Latency with zero-wait memory: 4 cycles per non-memory instruction, 5 for LD/ST, plus 1 per wait cycle.
- Step mode:
  - Each go rising edge executes exactly one instruction.
  - go held high does not retrigger.
  - An edge that arrives while the core is not in IDLE is discarded.
- Dropping run_mode mid-instruction: the current instruction completes, then the core enters IDLE.
- Reset: state=IDLE, pc=0, all registers=0, flags=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0, go edge detector cleared.
  - Reset asserted mid-transfer drops mem_req immediately.

Optional Feature:
- Macro: VM_CORE_BREAKPOINT_EN.
- When defined:
  - Adds ports bp_en (in, 1), bp_addr (in, AW) and bp_hit (out, 1, reset 0).
  - In free-run, the transition into FETCH with bp_en=1 and pc==bp_addr goes to IDLE instead, with bp_hit=1 and no fetch.
  - The next go edge clears bp_hit and executes the breakpointed instruction without re-checking the breakpoint.
- When undefined: the ports are absent and behaviour is as described above.

Test Plan:
1. Program LDI r1,5; LDI r2,3; ADD r1,r2; HLT at address 0, run_mode=1, one go pulse, zero-wait memory -> r1=0x8, Z=0, C=0, halted=1, pc=4, state=6.
2. LDI r1,7; LDI r2,7; SUB r1,r2; JZ 0x10, with NOP at 0x10 -> Z=1, C=0, pc=0x10 after the JZ, then 0x11 after the NOP.
3. Step mode with run_mode=0 over a NOP stream -> pc advances by exactly 1 per go edge; go held high for 20 cycles advances it only once.
4. LDI r3,0x20; ST r4 (=0xDEADBEEF) to [r3]; LD r5 from [r3]; memory inserts 3 wait cycles -> mem_req stays high 4 cycles per transfer with constant addr 0x20; r5=0xDEADBEEF, Z=0.
5. JMP 0xFF with NOP at 0xFF, AW=8 -> after the NOP pc=0x00 and the next fetch is from address 0.
6. Assert rst during a MEM-state write with ack withheld -> mem_req=0 and mem_we=0 immediately; pc=0; state=0; dbg_data=0 for every dbg_sel.
